// File: rtl/cacheline_burst_adapter.sv
// Cache line <-> burst memory adapter.
// Accepts whole-line pmem read/write requests, runs a fixed-length burst of
// beats on the memory side and returns a single-cycle pmem_resp when the
// line has been fully transferred.
module cacheline_burst_adapter #(
   parameter int unsigned SLine   = 256,
   parameter int unsigned SBurst  = 64,
   parameter int unsigned SOffset = 5
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              pmem_read_i,
   input  logic              pmem_write_i,
   input  logic [31:0]       pmem_address_i,
   input  logic [SLine-1:0]  pmem_wdata_i,
   output logic [SLine-1:0]  pmem_rdata_o,
   output logic              pmem_resp_o,
   output logic [31:0]       burst_address_o,
   output logic              burst_read_o,
   output logic              burst_write_o,
   output logic [SBurst-1:0] burst_wdata_o,
   input  logic [SBurst-1:0] burst_rdata_i,
   input  logic              burst_resp_i
);

   localparam int unsigned NumBeats = SLine / SBurst;
   localparam int unsigned CntW     = $clog2(NumBeats);
   localparam logic [CntW-1:0] LastCnt = CntW'(NumBeats - 1);

   typedef enum logic [1:0] {StIdle, StRead, StWrite, StResp} state_e;

   state_e            state_q;
   logic [CntW-1:0]   cnt_q;
   logic [SLine-1:0]  buf_q;
   logic [SLine-1:0]  buf_upd;
   logic [SLine-1:0]  pmem_rdata_q;
   logic [31:0]       burst_address_q;
   logic              pmem_resp_q;
   logic              burst_read_q;
   logic              burst_write_q;

   // Line buffer with the incoming read beat merged into slice cnt
   always_comb begin
      buf_upd = buf_q;
      buf_upd[cnt_q*SBurst +: SBurst] = burst_rdata_i;
   end

   // Transaction FSM: state, beat counter, line buffer and registered outputs
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q         <= StIdle;
         cnt_q           <= '0;
         buf_q           <= '0;
         pmem_rdata_q    <= '0;
         burst_address_q <= '0;
         pmem_resp_q     <= 1'b0;
         burst_read_q    <= 1'b0;
         burst_write_q   <= 1'b0;
      end else begin
         pmem_resp_q <= 1'b0;
         case (state_q)
            StIdle: begin
               // Writeback wins over refill when both are requested
               if (pmem_write_i) begin
                  burst_address_q <= {pmem_address_i[31:SOffset], {SOffset{1'b0}}};
                  buf_q           <= pmem_wdata_i;
                  cnt_q           <= '0;
                  burst_write_q   <= 1'b1;
                  state_q         <= StWrite;
               end else if (pmem_read_i) begin
                  burst_address_q <= {pmem_address_i[31:SOffset], {SOffset{1'b0}}};
                  cnt_q           <= '0;
                  burst_read_q    <= 1'b1;
                  state_q         <= StRead;
               end
            end
            StRead: begin
               if (burst_resp_i) begin
                  buf_q <= buf_upd;
                  cnt_q <= cnt_q + CntW'(1);
                  if (cnt_q == LastCnt) begin
                     // Publish the full line on the same edge that raises pmem_resp
                     pmem_rdata_q <= buf_upd;
                     burst_read_q <= 1'b0;
                     pmem_resp_q  <= 1'b1;
                     state_q      <= StResp;
                  end
               end
            end
            StWrite: begin
               if (burst_resp_i) begin
                  cnt_q <= cnt_q + CntW'(1);
                  if (cnt_q == LastCnt) begin
                     burst_write_q <= 1'b0;
                     pmem_resp_q   <= 1'b1;
                     state_q       <= StResp;
                  end
               end
            end
            StResp: begin
               state_q <= StIdle;
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign pmem_rdata_o    = pmem_rdata_q;
   assign pmem_resp_o     = pmem_resp_q;
   assign burst_address_o = burst_address_q;
   assign burst_read_o    = burst_read_q;
   assign burst_write_o   = burst_write_q;
   assign burst_wdata_o   = buf_q[cnt_q*SBurst +: SBurst];

endmodule

// File: tb/tb_cacheline_burst_adapter.sv
// Scoreboard bench for cacheline_burst_adapter: a stimulus process issues line
// transactions and pushes expectations, a memory responder feeds/consumes
// beats with random stalls, and a monitor checks every pmem_resp.
module tb_cacheline_burst_adapter;

   logic         clk_i = 1'b0;
   logic         rst_i;
   logic         pmem_read_i, pmem_write_i;
   logic [31:0]  pmem_address_i;
   logic [255:0] pmem_wdata_i;
   logic [255:0] pmem_rdata_o;
   logic         pmem_resp_o;
   logic [31:0]  burst_address_o;
   logic         burst_read_o, burst_write_o;
   logic [63:0]  burst_wdata_o;
   logic [63:0]  burst_rdata_i;
   logic         burst_resp_i;

   cacheline_burst_adapter dut (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .pmem_read_i    (pmem_read_i),
      .pmem_write_i   (pmem_write_i),
      .pmem_address_i (pmem_address_i),
      .pmem_wdata_i   (pmem_wdata_i),
      .pmem_rdata_o   (pmem_rdata_o),
      .pmem_resp_o    (pmem_resp_o),
      .burst_address_o(burst_address_o),
      .burst_read_o   (burst_read_o),
      .burst_write_o  (burst_write_o),
      .burst_wdata_o  (burst_wdata_o),
      .burst_rdata_i  (burst_rdata_i),
      .burst_resp_i   (burst_resp_i)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      bit           is_wr;
      logic [255:0] rdata;
   } exp_t;

   exp_t         exp_q[$];
   logic [63:0]  rd_beats_q[$];
   logic [63:0]  wr_beats_q[$];
   logic [255:0] last_read = '0;
   logic [31:0]  exp_addr = '0;
   int           stall_pct = 0;
   int           idle_strobe_pct = 50;
   int           n_checks = 0;
   int           n_fails = 0;

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic flag_fail(input string name);
      n_checks++;
      n_fails++;
      $display("FAIL %s", name);
   endtask

   function automatic logic [255:0] rand_line();
      logic [255:0] l;
      for (int i = 0; i < 8; i++) l[32*i +: 32] = $urandom;
      return l;
   endfunction

   // Memory responder: strobes beats, supplies read data, checks write data/address
   initial begin
      burst_resp_i  = 1'b0;
      burst_rdata_i = '0;
      forever begin
         logic go;
         @(negedge clk_i);
         if (rst_i) begin
            burst_resp_i = 1'b0;
            continue;
         end
         if (burst_read_o || burst_write_o) begin
            go = ($urandom_range(99) >= stall_pct);
            chk("burst_address", {224'd0, burst_address_o}, {224'd0, exp_addr});
            if (burst_read_o && burst_write_o) flag_fail("read_and_write_together");
         end else begin
            go = ($urandom_range(99) < idle_strobe_pct);
         end
         burst_resp_i  = go;
         burst_rdata_i = {$urandom, $urandom};
         if (go && burst_read_o) begin
            if (rd_beats_q.size() == 0) flag_fail("unexpected_read_beat");
            else burst_rdata_i = rd_beats_q.pop_front();
         end
         if (go && burst_write_o) begin
            if (wr_beats_q.size() == 0) flag_fail("unexpected_write_beat");
            else chk("burst_wdata", {192'd0, burst_wdata_o}, {192'd0, wr_beats_q.pop_front()});
         end
      end
   end

   // Monitor: every pmem_resp pops one expectation
   initial begin
      bit prev_resp = 1'b0;
      forever begin
         @(negedge clk_i);
         if (pmem_resp_o) begin
            chk("resp_single_cycle", {255'd0, prev_resp}, 256'd0);
            chk("resp_burst_idle", {254'd0, burst_read_o, burst_write_o}, 256'd0);
            if (exp_q.size() == 0) begin
               flag_fail("unexpected_pmem_resp");
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               chk("pmem_rdata", pmem_rdata_o, e.rdata);
               if (e.is_wr) chk("write_beats_left", 256'(wr_beats_q.size()), 256'd0);
               else         chk("read_beats_left", 256'(rd_beats_q.size()), 256'd0);
            end
         end
         prev_resp = pmem_resp_o;
      end
   end

   task automatic do_reset();
      rst_i = 1'b1;
      pmem_read_i  = 1'b0;
      pmem_write_i = 1'b0;
      exp_q.delete();
      rd_beats_q.delete();
      wr_beats_q.delete();
      last_read = '0;
      repeat (2) @(negedge clk_i);
      rst_i = 1'b0;
   endtask

   // Issue one transaction, push its expectation, wait for pmem_resp
   task automatic run_txn(input bit wr, input bit also_rd, input bit keep_rd,
                          input logic [31:0] addr, input int stall, output int lat);
      logic [255:0] wdata, line;
      exp_t         e;
      bit           got;
      wdata = rand_line();
      e.is_wr = wr;
      if (wr) begin
         for (int i = 0; i < 4; i++) wr_beats_q.push_back(wdata[64*i +: 64]);
         e.rdata = last_read;
      end else begin
         line = rand_line();
         for (int i = 0; i < 4; i++) rd_beats_q.push_back(line[64*i +: 64]);
         last_read = line;
         e.rdata = line;
      end
      exp_q.push_back(e);
      exp_addr       = addr & ~32'h1f;
      stall_pct      = stall;
      pmem_address_i = addr;
      pmem_wdata_i   = wdata;
      pmem_write_i   = wr;
      pmem_read_i    = !wr || also_rd;
      got = 1'b0;
      lat = 0;
      while (!got && lat < 200) begin
         @(negedge clk_i);
         lat++;
         if (pmem_resp_o) got = 1'b1;
         else if (burst_read_o || burst_write_o) begin
            // Request-side changes during a burst must be ignored
            pmem_address_i = $urandom;
            pmem_wdata_i   = rand_line();
         end
      end
      pmem_write_i = 1'b0;
      pmem_read_i  = keep_rd;
      #1;
      if (!got) begin
         flag_fail("pmem_resp_timeout");
         do_reset();
      end
   endtask

   initial begin
      int lat;
      pmem_address_i = '0;
      pmem_wdata_i   = '0;
      do_reset();
      rst_i = 1'b1;
      #1;
      chk("reset_rdata", pmem_rdata_o, 256'd0);
      chk("reset_ctrl", {253'd0, pmem_resp_o, burst_read_o, burst_write_o}, 256'd0);
      chk("reset_addr", {224'd0, burst_address_o}, 256'd0);
      chk("reset_wdata", {192'd0, burst_wdata_o}, 256'd0);
      @(negedge clk_i);
      rst_i = 1'b0;
      repeat (2) @(negedge clk_i);

      // Read without stalls: response 5 cycles after the request
      run_txn(1'b0, 1'b0, 1'b0, 32'h1234_5678, 0, lat);
      chk("read_latency", 256'(lat), 256'd5);
      repeat (2) @(negedge clk_i);

      // Write with stalls, then no-stall write latency
      run_txn(1'b1, 1'b0, 1'b0, 32'hdead_beef, 50, lat);
      repeat (2) @(negedge clk_i);
      run_txn(1'b1, 1'b0, 1'b0, 32'h0000_1040, 0, lat);
      chk("write_latency", 256'(lat), 256'd5);

      // Simultaneous request: write first, held read follows
      repeat (2) @(negedge clk_i);
      run_txn(1'b1, 1'b1, 1'b1, 32'h8000_0020, 30, lat);
      run_txn(1'b0, 1'b0, 1'b0, 32'h8000_0020, 30, lat);

      // Spurious strobes while idle, then a read
      idle_strobe_pct = 100;
      repeat (3) @(negedge clk_i);
      run_txn(1'b0, 1'b0, 1'b0, 32'h0bad_f00d, 0, lat);
      idle_strobe_pct = 50;

      // Reset mid-burst aborts the read without exposing partial data
      repeat (2) @(negedge clk_i);
      begin
         logic [255:0] line;
         int           guard;
         line = rand_line();
         for (int i = 0; i < 4; i++) rd_beats_q.push_back(line[64*i +: 64]);
         exp_addr    = 32'h4000_0100;
         stall_pct   = 0;
         pmem_address_i = 32'h4000_0111;
         pmem_read_i = 1'b1;
         guard = 0;
         while (rd_beats_q.size() > 2 && guard < 50) begin
            @(negedge clk_i);
            guard++;
         end
         if (guard >= 50) flag_fail("mid_burst_wait_timeout");
         @(posedge clk_i);
         #2;
         rst_i = 1'b1;
         #1;
         chk("abort_ctrl", {253'd0, pmem_resp_o, burst_read_o, burst_write_o}, 256'd0);
         chk("abort_rdata", pmem_rdata_o, 256'd0);
         rd_beats_q.delete();
         exp_q.delete();
         last_read   = '0;
         pmem_read_i = 1'b0;
         repeat (2) @(negedge clk_i);
         rst_i = 1'b0;
      end
      run_txn(1'b0, 1'b0, 1'b0, 32'h4000_0111, 20, lat);

      // Randomized back-to-back traffic
      for (int t = 0; t < 40; t++) begin
         bit wr;
         wr = $urandom_range(1);
         run_txn(wr, 1'b0, 1'b0, $urandom, $urandom_range(70), lat);
         repeat ($urandom_range(2)) @(negedge clk_i);
      end

      repeat (4) @(negedge clk_i);
      chk("exp_queue_drained", 256'(exp_q.size()), 256'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
